// File: rtl/key_debounce.sv
// key_debounce: synchronizes active-low push buttons and turns each into a
// debounced level plus one-cycle press, release and long-press pulses.
// Every key has its own debounce counter, hold counter and small FSM.
module key_debounce #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int CNT_W           = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_rel,
    output logic [N_KEYS-1:0] key_long
);

    // Debounce accepts on the DEBOUNCE_CYCLES-th consecutive sample; a
    // single-cycle debounce therefore skips the pending states entirely.
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam bit               DB_SINGLE = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_PEND,
        HELD,
        RELEASE_PEND
    } key_fsm_t;

    logic [N_KEYS-1:0] sync1_reg;
    logic [N_KEYS-1:0] sync2_reg;

    // Two-flop synchronizer; idles at 1 so a reset looks like "released".
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_reg <= '1;
            sync2_reg <= '1;
        end else begin
            sync1_reg <= key_n;
            sync2_reg <= sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_key
            key_fsm_t         fsm_reg, fsm_next;
            logic [CNT_W-1:0] db_cnt_reg, db_cnt_next;
            logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
            logic             state_reg, state_next;
            logic             press_reg, press_next;
            logic             rel_reg, rel_next;
            logic             long_reg, long_next;
            logic             s;
            logic [CNT_W-1:0] hold_inc;
            logic             long_hit;

            assign s        = ~sync2_reg[gi];
            // Hold counter saturates so the long pulse can only fire once.
            assign hold_inc = (hold_cnt_reg == LONG_MAX) ? hold_cnt_reg
                                                         : hold_cnt_reg + CNT_ONE;
            assign long_hit = (hold_cnt_reg == LONG_LAST);

            // Per-key state, counters and registered event outputs.
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    fsm_reg      <= IDLE;
                    db_cnt_reg   <= '0;
                    hold_cnt_reg <= '0;
                    state_reg    <= 1'b0;
                    press_reg    <= 1'b0;
                    rel_reg      <= 1'b0;
                    long_reg     <= 1'b0;
                end else begin
                    fsm_reg      <= fsm_next;
                    db_cnt_reg   <= db_cnt_next;
                    hold_cnt_reg <= hold_cnt_next;
                    state_reg    <= state_next;
                    press_reg    <= press_next;
                    rel_reg      <= rel_next;
                    long_reg     <= long_next;
                end
            end

            // Next-state logic: debounce in the pending states, hold timing
            // whenever the key is accepted as pressed.
            always_comb begin
                fsm_next      = fsm_reg;
                db_cnt_next   = db_cnt_reg;
                hold_cnt_next = hold_cnt_reg;
                state_next    = state_reg;
                press_next    = 1'b0;
                rel_next      = 1'b0;
                long_next     = 1'b0;
                case (fsm_reg)
                    IDLE: begin
                        if (s) begin
                            if (DB_SINGLE) begin
                                fsm_next      = HELD;
                                state_next    = 1'b1;
                                press_next    = 1'b1;
                                hold_cnt_next = '0;
                                db_cnt_next   = '0;
                            end else begin
                                fsm_next    = PRESS_PEND;
                                db_cnt_next = CNT_ONE;
                            end
                        end
                    end
                    PRESS_PEND: begin
                        if (!s) begin
                            fsm_next    = IDLE;
                            db_cnt_next = '0;
                        end else if (db_cnt_reg == DB_LAST) begin
                            fsm_next      = HELD;
                            state_next    = 1'b1;
                            press_next    = 1'b1;
                            hold_cnt_next = '0;
                            db_cnt_next   = '0;
                        end else begin
                            db_cnt_next = db_cnt_reg + CNT_ONE;
                        end
                    end
                    HELD: begin
                        hold_cnt_next = hold_inc;
                        long_next     = long_hit;
                        if (!s) begin
                            if (DB_SINGLE) begin
                                // Accepted release clears the hold, so no long event.
                                fsm_next      = IDLE;
                                state_next    = 1'b0;
                                rel_next      = 1'b1;
                                hold_cnt_next = '0;
                                long_next     = 1'b0;
                            end else begin
                                fsm_next    = RELEASE_PEND;
                                db_cnt_next = CNT_ONE;
                            end
                        end
                    end
                    RELEASE_PEND: begin
                        hold_cnt_next = hold_inc;
                        long_next     = long_hit;
                        if (s) begin
                            fsm_next    = HELD;
                            db_cnt_next = '0;
                        end else if (db_cnt_reg == DB_LAST) begin
                            fsm_next      = IDLE;
                            state_next    = 1'b0;
                            rel_next      = 1'b1;
                            hold_cnt_next = '0;
                            db_cnt_next   = '0;
                            long_next     = 1'b0;
                        end else begin
                            db_cnt_next = db_cnt_reg + CNT_ONE;
                        end
                    end
                    default: begin
                        fsm_next = IDLE;
                    end
                endcase
            end

            assign key_state[gi] = state_reg;
            assign key_press[gi] = press_reg;
            assign key_rel[gi]   = rel_reg;
            assign key_long[gi]  = long_reg;
        end
    endgenerate

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed scenarios with literal expectations followed by
// randomized key activity, all checked against a run-length debounce model.
module tb_key_debounce;

    localparam int NK   = 4;
    localparam int DC   = 8;
    localparam int LONG = 32;

    logic          clk;
    logic          nrst;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_state, key_press, key_rel, key_long;

    int tests  = 0;
    int failed = 0;

    key_debounce #(
        .N_KEYS(NK), .DEBOUNCE_CYCLES(DC), .LONG_CYCLES(LONG), .CNT_W(16)
    ) dut (
        .clk(clk), .nrst(nrst), .key_n(key_n),
        .key_state(key_state), .key_press(key_press),
        .key_rel(key_rel), .key_long(key_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a change is accepted once the synchronized level has
    // differed from the accepted level for DC consecutive samples; a long
    // event fires exactly LONG edges after the accepted press if still held.
    logic [NK-1:0] m_sy1, m_sy2, m_st, m_press, m_rel, m_long;
    int            m_run [NK];
    int            m_pcyc[NK];
    int            cyc;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_sy1 = '1; m_sy2 = '1; m_st = '0;
            m_press = '0; m_rel = '0; m_long = '0;
            for (int k = 0; k < NK; k++) m_run[k] = 0;
        end else begin
            cyc++;
            for (int k = 0; k < NK; k++) begin
                logic s;
                s = ~m_sy2[k];
                m_press[k] = 1'b0; m_rel[k] = 1'b0; m_long[k] = 1'b0;
                if (s != m_st[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DC) begin
                        m_st[k]  = s;
                        m_run[k] = 0;
                        if (s) begin
                            m_press[k] = 1'b1;
                            m_pcyc[k]  = cyc;
                        end else begin
                            m_rel[k] = 1'b1;
                        end
                    end
                end else begin
                    m_run[k] = 0;
                end
                if (m_st[k] && cyc == m_pcyc[k] + LONG) m_long[k] = 1'b1;
            end
            m_sy2 = m_sy1;
            m_sy1 = key_n;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the clock edge.
    always @(posedge clk) begin
        #2;
        check("model_state", 32'(key_state), 32'(m_st));
        check("model_press", 32'(key_press), 32'(m_press));
        check("model_rel",   32'(key_rel),   32'(m_rel));
        check("model_long",  32'(key_long),  32'(m_long));
        if ((key_press | key_rel | key_long) != '0)
            $display("[TB] t=%0t press=%b rel=%b long=%b state=%b",
                     $time, key_press, key_rel, key_long, key_state);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Called at the sampling point; asserts reset between edges.
    task automatic do_reset(input int hold);
        #3 nrst = 1'b0;
        #1;
        check("rst_state", 32'(key_state), 32'h0);
        check("rst_press", 32'(key_press), 32'h0);
        check("rst_rel",   32'(key_rel),   32'h0);
        check("rst_long",  32'(key_long),  32'h0);
        repeat (hold) @(posedge clk);
        #3 nrst = 1'b1;
    endtask

    initial begin
        int rate;
        nrst  = 1'b0;
        key_n = '1;
        cyc   = 0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_outputs", 32'({key_state, key_press, key_rel, key_long}), 32'h0);
        #3 nrst = 1'b1;
        step();

        // 1: key 0 press appears on the 10th edge after the pin edge
        key_n[0] = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            check("t1_press", 32'(key_press), (i == 10) ? 32'h1 : 32'h0);
            check("t1_state", 32'(key_state), (i >= 10) ? 32'h1 : 32'h0);
        end

        // 2: a 5-cycle bounce on key 1 is discarded
        key_n[1] = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if (i == 6) key_n[1] = 1'b1;
            step();
            check("t2_press1", 32'(key_press[1]), 32'h0);
            check("t2_state1", 32'(key_state[1]), 32'h0);
        end

        // 3: hold key 2, single long pulse 32 cycles after press, then release
        key_n[2] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            check("t3_press2", 32'(key_press[2]), (i == 10) ? 32'h1 : 32'h0);
        end
        for (int j = 1; j <= 100; j++) begin
            step();
            check("t3_long2", 32'(key_long[2]), (j == 32) ? 32'h1 : 32'h0);
        end
        key_n[2] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            check("t3_rel2", 32'(key_rel[2]), (i == 10) ? 32'h1 : 32'h0);
        end

        // 4: 3-cycle release glitch while held on key 3
        key_n[3] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            check("t4_press3", 32'(key_press[3]), (i == 10) ? 32'h1 : 32'h0);
        end
        for (int j = 1; j <= 40; j++) begin
            if (j == 5) key_n[3] = 1'b1;
            if (j == 8) key_n[3] = 1'b0;
            step();
            check("t4_rel3",   32'(key_rel[3]),   32'h0);
            check("t4_state3", 32'(key_state[3]), 32'h1);
            check("t4_long3",  32'(key_long[3]),  (j == 32) ? 32'h1 : 32'h0);
        end

        // 5: simultaneous press and release of all keys
        key_n = '1;
        repeat (20) step();
        check("t5_idle", 32'(key_state), 32'h0);
        key_n = '0;
        for (int i = 1; i <= 10; i++) begin
            step();
            check("t5_press", 32'(key_press), (i == 10) ? 32'hF : 32'h0);
        end
        repeat (50) step();
        key_n = '1;
        for (int i = 1; i <= 10; i++) begin
            step();
            check("t5_rel", 32'(key_rel), (i == 10) ? 32'hF : 32'h0);
        end
        repeat (5) step();

        // 6: reset during PRESS_PEND, then during HELD
        key_n[0] = 1'b0;
        repeat (5) step();
        do_reset(3);
        for (int i = 1; i <= 12; i++) begin
            step();
            check("t6a_press", 32'(key_press), (i == 10) ? 32'h1 : 32'h0);
        end
        repeat (3) step();
        do_reset(2);
        for (int i = 1; i <= 12; i++) begin
            step();
            check("t6b_press", 32'(key_press), (i == 10) ? 32'h1 : 32'h0);
            check("t6b_rel",   32'(key_rel),   32'h0);
        end

        // Randomized activity with varying bounce rates and rare resets
        rate = 5;
        for (int n = 0; n < 4000; n++) begin
            if (n % 500 == 0) begin
                case ($urandom_range(0, 3))
                    0: rate = 5;
                    1: rate = 40;
                    2: rate = 150;
                    default: rate = 400;
                endcase
            end
            for (int k = 0; k < NK; k++)
                if ($urandom_range(0, 999) < rate) key_n[k] = ~key_n[k];
            if ($urandom_range(0, 1999) == 0) do_reset(2);
            step();
        end

        key_n = '1;
        repeat (20) step();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
